// File: rtl/seg_display_mux.sv
// Four-digit time-multiplexed seven-segment driver with frame shadowing, anti-ghost guard and adjust blink.
// Define STOPWATCH_BLINK_EN to build the blink counter and field blanking; otherwise all digits stay visible.
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutes_tens,
  input  logic [3:0] minutes_ones,
  input  logic [3:0] seconds_tens,
  input  logic [3:0] seconds_ones,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] GUARD_C = RW'(GUARD);

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    sh_mt, sh_mo, sh_st, sh_so;
  logic          slot_end;
  logic          in_guard;
  logic          field_blank;
  logic [3:0]    cur_digit;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign slot_end = (refresh_cnt == RF_LAST);
  assign in_guard = (refresh_cnt < GUARD_C);

  // Shadow is loaded only as the index wraps 3->0 so a frame never mixes two counter values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      sh_mt       <= '0;
      sh_mo       <= '0;
      sh_st       <= '0;
      sh_so       <= '0;
    end else begin
      refresh_cnt <= slot_end ? '0 : refresh_cnt + 1'b1;
      if (slot_end) begin
        digit_idx <= digit_idx + 2'd1;
        if (digit_idx == 2'd3) begin
          sh_mt <= minutes_tens;
          sh_mo <= minutes_ones;
          sh_st <= seconds_tens;
          sh_so <= seconds_ones;
        end
      end
    end
  end

`ifdef STOPWATCH_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (!adj) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // adj and sel are used live so dropping adj or moving sel takes effect on the next update.
  assign field_blank = adj & blink_off & (sel ? ~digit_idx[1] : digit_idx[1]);
`else
  localparam int unsigned unused_blink_div = BLINK_DIV;
  logic unused_adjust;
  assign unused_adjust = adj ^ sel;
  assign field_blank   = 1'b0;
`endif

  always_comb begin
    cur_digit = sh_so;
    case (digit_idx)
      2'd0: cur_digit = sh_so;
      2'd1: cur_digit = sh_st;
      2'd2: cur_digit = sh_mo;
      2'd3: cur_digit = sh_mt;
      default: cur_digit = sh_so;
    endcase
  end

  always_comb begin
    an_d  = in_guard ? 4'b1111 : ~(4'b0001 << digit_idx);
    seg_d = field_blank ? 7'b1111111 : decode(cur_digit);
    // The separator follows the anode so it never lights during the guard interval.
    dp_d  = ~((digit_idx == 2'd2) && !in_guard);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed self-checking bench for seg_display_mux (REFRESH_DIV=4, GUARD=1, BLINK_DIV=8).
// Blink expectations apply only when STOPWATCH_BLINK_EN is defined; otherwise nothing may blank.
module tb_seg_display_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mt = 4'd0, mo = 4'd0, st = 4'd0, so = 4'd0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg_display_mux #(.REFRESH_DIV(4), .GUARD(1), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst),
    .minutes_tens(mt), .minutes_ones(mo), .seconds_tens(st), .seconds_ones(so),
    .adj(adj), .sel(sel), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

`ifdef STOPWATCH_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  int unsigned total = 0, passed = 0, failed = 0;
  logic [6:0]  lut [16];
  int          p;           // frame position of the output just sampled (0..15)
  int          k;           // edges since adj rose
  logic [15:0] shown;       // {mt,mo,st,so} the current frame must display
  logic [15:0] pending;     // value captured at the end of the current frame
  logic        blanked;     // blink phase is blank for the sampled output
  logic        sel_e;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    p = 15; k = 0; shown = '0; pending = '0; blanked = 1'b0; sel_e = 1'b0;
  endtask

  task automatic step();
    logic        adj_e;
    logic [15:0] in_e;
    adj_e = adj;
    sel_e = sel;
    in_e  = {mt, mo, st, so};
    @(posedge clk);
    #1;
    p = (p + 1) % 16;
    if (p == 0) shown = pending;
    if (p == 15) pending = in_e;
    blanked = adj_e && BLINK_EN && (((k / 8) % 2) == 1);
    if (adj_e) k++;
    else k = 0;
  endtask

  task automatic check_cycle();
    int         s, pos;
    logic [3:0] d, exp_an;
    logic       mask;
    s      = p / 4;
    pos    = p % 4;
    d      = shown[s*4 +: 4];
    mask   = blanked && (sel_e ? (s < 2) : (s >= 2));
    exp_an = (pos == 0) ? 4'b1111 : ~(4'b0001 << s);
    chk($sformatf("an p%0d", p),  {3'b000, an}, {3'b000, exp_an});
    chk($sformatf("seg p%0d", p), seg, mask ? 7'b1111111 : lut[d]);
    chk($sformatf("dp p%0d", p),  {6'b0, dp}, {6'b0, (s == 2 && pos != 0) ? 1'b0 : 1'b1});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_cycle();
    end
  endtask

  initial begin
    lut[0]  = 7'b1000000; lut[1]  = 7'b1111001; lut[2]  = 7'b0100100; lut[3]  = 7'b0110000;
    lut[4]  = 7'b0011001; lut[5]  = 7'b0010010; lut[6]  = 7'b0000010; lut[7]  = 7'b1111000;
    lut[8]  = 7'b0000000; lut[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) lut[i] = 7'b1111111;

    // Reset values
    mt = 4'd1; mo = 4'd2; st = 4'd3; so = 4'd4;
    @(posedge clk); #1;
    chk("reset an", {3'b000, an}, 7'b0001111);
    chk("reset seg", seg, 7'b1111111);
    chk("reset dp", {6'b0, dp}, 7'd1);
    rst = 1'b0;
    model_reset();

    // Frame 1 shows zeros, frame 2 shows 12:34
    run(16);
    run(8);
    mt = 4'd0; mo = 4'd9; st = 4'd5; so = 4'd9;
    run(8);

    // Frame 3 stays 09:59 although inputs change mid-frame; frame 4 shows 10:00
    run(8);
    mt = 4'd1; mo = 4'd0; st = 4'd0; so = 4'd0;
    run(8);
    st = 4'hC;
    run(16);
    run(16);

    // Blink on minutes, then move to seconds mid-phase
    adj = 1'b1; sel = 1'b0;
    run(20);
    sel = 1'b1;
    run(20);
    // k is now 40: blank phase; dropping adj must give a visible next update
    adj = 1'b0;
    run(4);
    adj = 1'b1;
    run(24);
    run(40);

    // Asynchronous reset mid-slot
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async an", {3'b000, an}, 7'b0001111);
    chk("async seg", seg, 7'b1111111);
    chk("async dp", {6'b0, dp}, 7'd1);
    @(posedge clk); #1;
    chk("held an", {3'b000, an}, 7'b0001111);
    rst = 1'b0;
    model_reset();
    adj = 1'b0;
    run(32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
